// File: rtl/tt_um_prampal_lut_array.sv
// Purpose: NUM_LUTS programmable LUT_INPUTS-input look-up tables on shared pins, serially reprogrammed with an atomic commit.
// Latency: input change to uo_out is 1 clk (3 clk when TT_LUT_INPUT_SYNC_EN adds a 2-flop input synchronizer).
// Backpressure: none; a config bit is taken per cfg_strobe rising edge, and strobes beyond a full table set are ignored.
// Optional feature macro: TT_LUT_INPUT_SYNC_EN (defined: ui_in[6:0] pass through a 2-flop synchronizer first).
module tt_um_prampal_lut_array #(
  parameter int         NUM_LUTS     = 4,
  parameter int         LUT_INPUTS   = 3,
  parameter logic [7:0] RESET_TABLE0 = 8'h8F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Entries per table and total configuration bits across all tables.
  localparam int TBL   = 1 << LUT_INPUTS;
  localparam int TOTAL = NUM_LUTS * TBL;

  localparam logic [5:0]       TOTAL_CNT  = 6'(TOTAL);
  // LUT0 reset table keeps the old fixed tile behaviour; every other LUT starts at 0.
  localparam logic [TOTAL-1:0] ACTIVE_RST = TOTAL'(RESET_TABLE0[TBL-1:0]);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [6:0] in_s;

`ifdef TT_LUT_INPUT_SYNC_EN
  logic [6:0] sync1_q;
  logic [6:0] sync2_q;

  // Two-flop synchronizer ahead of all logic for asynchronous pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ui_in[6:0];
      sync2_q <= sync1_q;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = ui_in[6:0];
`endif

  logic [LUT_INPUTS-1:0] idx;
  logic                  cfg_en;
  logic                  cfg_bit;
  logic                  cfg_strobe;
  logic                  freeze;

  assign idx        = in_s[LUT_INPUTS-1:0];
  assign cfg_en     = in_s[3];
  assign cfg_bit    = in_s[4];
  assign cfg_strobe = in_s[5];
  assign freeze     = in_s[6];

  // ---------------------------------------------------------------------------
  // Strobe edge detection
  // ---------------------------------------------------------------------------
  logic strobe_q;
  logic strobe_edge;

  // Remember last strobe level so a held strobe yields exactly one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= cfg_strobe;
    end
  end

  assign strobe_edge = cfg_strobe & ~strobe_q;

  // ---------------------------------------------------------------------------
  // Configuration state machine
  // ---------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [TOTAL-1:0] shadow_q;
  logic [TOTAL-1:0] shadow_d;
  logic [TOTAL-1:0] active_q;
  logic [TOTAL-1:0] active_d;
  logic [5:0]       bit_count_q;
  logic [5:0]       bit_count_d;
  logic             done_q;
  logic             done_d;
  logic             err_q;
  logic             err_d;

  // Next-state logic: shadow shifts MSB-first, active tables only change in COMMIT.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    bit_count_d = bit_count_q;
    done_d      = done_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (cfg_en) begin
          state_d     = LOAD;
          bit_count_d = '0;
          done_d      = 1'b0;
          shadow_d    = '0;
        end
      end

      LOAD: begin
        // Dropping cfg_en wins over a coincident strobe edge: abort, keep old tables.
        if (!cfg_en) begin
          state_d  = IDLE;
          err_d    = 1'b1;
          shadow_d = '0;
        end else if (strobe_edge) begin
          shadow_d    = {shadow_q[TOTAL-2:0], cfg_bit};
          bit_count_d = bit_count_q + 6'd1;
          if (bit_count_q == TOTAL_CNT - 6'd1) begin
            state_d = COMMIT;
          end
        end
      end

      COMMIT: begin
        active_d = shadow_q;
        done_d   = 1'b1;
        err_d    = 1'b0;
        state_d  = HOLD;
      end

      HOLD: begin
        // Further strobes are ignored here; bit_count stays at TOTAL.
        if (!cfg_en) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Configuration registers; reset mid-load restores the power-on tables too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      active_q    <= ACTIVE_RST;
      bit_count_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      bit_count_q <= bit_count_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // LUT evaluation
  // ---------------------------------------------------------------------------
  logic [NUM_LUTS-1:0] lut_val;
  logic [NUM_LUTS-1:0] out_q;

  // LUT i occupies active_q[i*TBL +: TBL]; entry n is the output for index n.
  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
    logic [TBL-1:0] tbl;
    assign tbl        = active_q[i*TBL +: TBL];
    assign lut_val[i] = tbl[idx];
  end

  // Registered LUT outputs; freeze holds the previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (!freeze) begin
      out_q <= lut_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------------
  logic [6:0] lut_field;
  logic       cfg_busy;

  // Unused LUT slots read as zero.
  always_comb begin
    lut_field                 = '0;
    lut_field[NUM_LUTS-1:0]   = out_q;
  end

  assign cfg_busy = (state_q != IDLE);
  assign uo_out   = {cfg_busy, lut_field};
  assign uio_out  = {bit_count_q, err_q, done_q};
  assign uio_oe   = 8'hFF;

  // Pins that carry no function in this tile.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7], in_s};

endmodule

// File: tb/tb_tt_um_prampal_lut_array.sv
// Purpose: directed, table-driven check of the LUT array: reset tables, loads, abort, stuck/extra strobes, freeze, reset mid-load.
// Latency: expects 1 clk input-to-output (3 clk when TT_LUT_INPUT_SYNC_EN is defined).
// Backpressure: not applicable; strobes are driven as 1-cycle-high pulses with a low cycle between.
module tb_tt_um_prampal_lut_array;

`ifdef TT_LUT_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic [2:0] abc = 3'd0;
  logic       en = 1'b0;
  logic       bitv = 1'b0;
  logic       stb = 1'b0;
  logic       frz = 1'b0;

  assign ui_in = {1'b0, frz, stb, bitv, en, abc};

  always #5 clk = ~clk;

  tt_um_prampal_lut_array dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0] abc;
    logic [7:0] exp_uo;
  } vec_t;

  vec_t vecs [0:19];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bitv = b;
    stb  = 1'b1;
    step(1);
    stb  = 1'b0;
    step(1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      abc = vecs[i].abc;
      step(LAT);
      check($sformatf("vec%0d_abc%0d", i, vecs[i].abc), uo_out, vecs[i].exp_uo);
    end
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (uio_out[0]) seen = 1'b1;
      else step(1);
    end
    check(name, {7'd0, seen}, 8'd1);
  endtask

  initial begin
    // Reset tables: LUT0 = 0x8F -> (A&B)|~C.
    vecs[0]  = '{3'd0, 8'h01};
    vecs[1]  = '{3'd1, 8'h01};
    vecs[2]  = '{3'd2, 8'h01};
    vecs[3]  = '{3'd3, 8'h01};
    vecs[4]  = '{3'd4, 8'h00};
    vecs[5]  = '{3'd5, 8'h00};
    vecs[6]  = '{3'd6, 8'h00};
    vecs[7]  = '{3'd7, 8'h01};
    // LUT3=FF, LUT2=00, LUT1=96, LUT0=80.
    vecs[8]  = '{3'd0, 8'h08};
    vecs[9]  = '{3'd1, 8'h0A};
    vecs[10] = '{3'd2, 8'h0A};
    vecs[11] = '{3'd3, 8'h08};
    vecs[12] = '{3'd4, 8'h0A};
    vecs[13] = '{3'd5, 8'h08};
    vecs[14] = '{3'd6, 8'h08};
    vecs[15] = '{3'd7, 8'h0B};
    // LUT3=0F, LUT2=3C, LUT1=A5, LUT0=01.
    vecs[16] = '{3'd0, 8'h0B};
    vecs[17] = '{3'd2, 8'h0E};
    vecs[18] = '{3'd5, 8'h06};
    vecs[19] = '{3'd7, 8'h02};

    // Reset state.
    rst_n = 1'b0;
    step(3);
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;

    // Power-on behaviour matches the old fixed tile.
    run_vecs(0, 7);

    // Stuck strobe: five high cycles count once.
    en = 1'b1;
    step(4);
    check("load_busy", {7'd0, uo_out[7]}, 8'd1);
    bitv = 1'b0;
    stb  = 1'b1;
    step(5);
    stb  = 1'b0;
    step(4);
    check("stuck_cnt", {2'b00, uio_out[7:2]}, 8'd1);
    en = 1'b0;
    step(4);
    check("stuck_abort_err", {7'd0, uio_out[1]}, 8'd1);
    check("stuck_abort_busy", {7'd0, uo_out[7]}, 8'd0);

    // Full load.
    abc = 3'd0;
    en  = 1'b1;
    step(4);
    send_word(32'hFF00_9680);
    wait_done("full_done");
    check("full_cnt", {2'b00, uio_out[7:2]}, 8'd32);
    check("full_err_clr", {7'd0, uio_out[1]}, 8'd0);
    step(3);
    check("hold_busy", {7'd0, uo_out[7]}, 8'd1);
    abc = 3'd7;
    step(LAT);
    check("hold_abc7", uo_out, 8'h8B);
    abc = 3'd3;
    step(LAT);
    check("hold_abc3", uo_out, 8'h88);
    en = 1'b0;
    step(4);
    check("done_sticky", {7'd0, uio_out[0]}, 8'd1);
    run_vecs(8, 15);

    // Aborted load after 10 bits keeps the previous tables.
    en = 1'b1;
    step(4);
    check("done_clr_on_load", {7'd0, uio_out[0]}, 8'd0);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    en = 1'b0;
    step(4);
    check("abort_err", {7'd0, uio_out[1]}, 8'd1);
    check("abort_cnt", {2'b00, uio_out[7:2]}, 8'd10);
    run_vecs(8, 15);

    // 40 pulses: only the first 32 bits land.
    en = 1'b1;
    step(4);
    send_word(32'h0F3C_A501);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    wait_done("extra_done");
    check("extra_cnt", {2'b00, uio_out[7:2]}, 8'd32);
    check("extra_err_clr", {7'd0, uio_out[1]}, 8'd0);
    en = 1'b0;
    step(4);
    run_vecs(16, 19);

    // Freeze holds outputs while inputs toggle; release updates one eval later.
    abc = 3'd0;
    step(LAT);
    check("frz_pre", uo_out, 8'h0B);
    frz = 1'b1;
    step(LAT + 1);
    abc = 3'd2;
    step(LAT);
    check("frz_abc2", uo_out, 8'h0B);
    abc = 3'd5;
    step(LAT);
    check("frz_abc5", uo_out, 8'h0B);
    abc = 3'd7;
    step(LAT);
    check("frz_abc7", uo_out, 8'h0B);
    frz = 1'b0;
    step(LAT);
    check("frz_release", uo_out, 8'h02);

    // Reset mid-load restores power-on tables.
    abc = 3'd0;
    en  = 1'b1;
    step(4);
    for (int i = 0; i < 16; i++) send_bit(i[0]);
    check("mid_cnt", {2'b00, uio_out[7:2]}, 8'd16);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("mid_rst_uo", uo_out, 8'h00);
    check("mid_rst_uio", uio_out, 8'h00);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("mid_post_uio", uio_out, 8'h00);
    run_vecs(0, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tt_um_prampal_lut_array.md
Name: tt_um_prampal_lut_array

Overview:
- Parametrised successor to the team's fixed three-input logic tile: NUM_LUTS programmable look-up tables, each with LUT_INPUTS inputs, all sharing the same input pins.
- Truth tables are loaded serially through a strobe-qualified configuration port into a shadow register, then committed atomically.
- Outputs are registered.
- Reset default makes LUT0 compute x = (A & B) | ~C, so a freshly reset chip behaves as the previous tile did.

Parameters:
- NUM_LUTS, 4, number of LUTs; legal range 1..7.
- LUT_INPUTS, 3, inputs per LUT (K); legal range 1..3; uses ui_in[K-1:0].
- RESET_TABLE0, 8'h8F, reset truth table of LUT0; low 2^K bits used. All other LUTs reset to 0.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  always 1 when powered; unused.
- ui_in  input  8  logic and configuration inputs:
  - [2:0] LUT inputs (index = {ui_in[2],ui_in[1],ui_in[0]} truncated to K bits).
  - [3] cfg_en (level).
  - [4] cfg_bit.
  - [5] cfg_strobe.
  - [6] freeze.
  - [7] unused.
- uo_out  output  8  [NUM_LUTS-1:0] LUT outputs; [6:NUM_LUTS] 0; [7] cfg_busy (state != IDLE).
- uio_in  input  8  unused.
- uio_out  output  8  [0] cfg_done; [1] cfg_err; [7:2] bit_count[5:0].
- uio_oe  output  8  constant 8'hFF.

Behaviour:
- Reset values:
  - uo_out = 0; uio_out = 0.
  - Active tables: LUT0 = RESET_TABLE0, others 0.
  - Shadow = 0; bit_count = 0; strobe history = 0; state = IDLE.
- Evaluation:
  - Each cycle, out_reg[i] <= table[i][idx] unless freeze=1; freeze=1 holds out_reg.
  - Latency: input change to uo_out is 1 clk (3 clk with SYNC option).
- Strobe edge: strobe_q registers cfg_strobe. A bit is accepted only on cycles where cfg_strobe=1 and strobe_q=0.
- TOTAL = NUM_LUTS * 2^K bits.
- Shift order: shadow <= {shadow[TOTAL-2:0], cfg_bit}. First bit sent is LUT[NUM_LUTS-1] entry 2^K-1; last bit sent is LUT0 entry 0.
- State machine:
  - IDLE: cfg_en=1 -> LOAD; clear bit_count and cfg_done.
  - LOAD:
    - On an accepted bit: shift, bit_count++.
    - When bit_count reaches TOTAL -> COMMIT on the following cycle.
    - cfg_en=0 with bit_count<TOTAL -> IDLE; set cfg_err; discard shadow; active tables unchanged.
  - COMMIT (1 cycle): copy shadow to active tables; set cfg_done; clear cfg_err -> HOLD.
  - HOLD: strobes ignored and bit_count frozen at TOTAL; cfg_en=0 -> IDLE.
- Tables used by evaluation change only in COMMIT. The first output using the new tables appears in the cycle after COMMIT.
- cfg_done and cfg_err are sticky:
  - cfg_done clears on entry to LOAD.
  - cfg_err clears on COMMIT or reset.
- Simultaneous strobe edge and cfg_en fall in LOAD: cfg_en wins; the bit is not accepted.
- Reset mid-load: everything returns to reset values, including the active tables.

Optional Feature:
- Macro: TT_LUT_INPUT_SYNC_EN.
- Defined: ui_in[6:0] pass through a 2-flop synchronizer, reset 0, before all logic. Eval latency is 3 clk; strobe edge detection is 2 clk later.
- Undefined: raw ui_in is used; eval latency is 1 clk.

Test Plan:
- Reset default: release rst_n, sweep {C,B,A} 0..7 -> uo_out[0] = 1,1,1,1,0,0,0,1; uo_out[3:1] = 0; uio_out = 0.
- Full load (defaults):
  - Setup: cfg_en=1, 32 strobe pulses carrying 0xFF (LUT3), 0x00 (LUT2), 0x96 (LUT1), 0x80 (LUT0), MSB first.
  - Required: bit_count = 32, then cfg_done=1 and cfg_busy=1 until cfg_en=0.
  - Check with inputs=3'b111: uo_out[3:0] = 4'b1011.
  - Check with inputs=3'b011: uo_out[3:0] = 4'b1000.
- Aborted load: 10 strobes then cfg_en=0 -> cfg_err=1, cfg_busy=0, outputs still follow previous tables.
- Stuck strobe / extra strobes: strobe held high 5 cycles -> exactly 1 bit counted; 40 pulses -> bit_count stops at 32, tables equal the first 32 bits.
- Freeze: freeze=1, toggle inputs -> uo_out constant; freeze=0 -> updates 1 clk later.
- Reset mid-load: assert rst_n=0 after 16 bits -> LUT0 = 0x8F behaviour, cfg_busy=0, bit_count=0.
